// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg
//   Shared definitions for the iterative shift-and-add multiplier:
//   FSM state encoding and the iteration-counter width helper.
package seq_multiplier_pkg;

    // 2'd3 is unused; the next-state logic sends it back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter width: clog2(WIDTH), never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_multiplier_add_shift_stage.sv
// seq_multiplier_add_shift_stage
//   One shift-and-add iteration, purely combinational.
//   Ports:
//     i_acc      [2W-1:0] current accumulator
//     i_mag_a    [W-1:0]  multiplicand magnitude
//     i_lsb               current multiplier LSB
//     o_acc_next [2W-1:0] accumulator after conditional add and right shift
module seq_multiplier_add_shift_stage #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_mag_a,
    input  logic               i_lsb,
    output logic [2*WIDTH-1:0] o_acc_next
);

    logic [WIDTH:0] w_sum;

    // W+1-bit add on the upper half; the carry becomes the new MSB after
    // the shift, so nothing is lost.
    assign w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_lsb ? {1'b0, i_mag_a} : '0);
    assign o_acc_next = {w_sum, i_acc[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Iterative WIDTH x WIDTH -> 2*WIDTH multiplier, unsigned or two's
//   complement. Multiplies magnitudes over WIDTH cycles, then applies
//   the sign once in the DONE cycle.
//   Ports:
//     clk, rst      rising-edge clock, async active-high reset
//     start         request, only looked at while idle
//     signed_mode   1 = two's-complement operands/result (captured with start)
//     a, b          multiplicand / multiplier (captured with start)
//     busy          high in CALC and DONE
//     done          one-cycle pulse when p updates
//     p             product, held until the next done
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int PW    = 2 * WIDTH;

    state_t             r_state, w_state_next;
    logic [PW-1:0]      r_acc, r_p;
    logic [WIDTH-1:0]   r_mag_a, r_mag_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg, r_done;

    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [PW-1:0]      w_acc_next, w_result;
    logic               w_last;

    // Magnitude of the most-negative value wraps to itself, which read as
    // unsigned is exactly 2^(W-1) -- the correct magnitude.
    assign w_mag_a  = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_mag_b  = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_result = r_neg ? (~r_acc + PW'(1)) : r_acc;

    seq_multiplier_add_shift_stage #(.WIDTH(WIDTH)) u_stage (
        .i_acc      (r_acc),
        .i_mag_a    (r_mag_a),
        .i_lsb      (r_mag_b[0]),
        .o_acc_next (w_acc_next)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_CALC;
            ST_CALC: if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_p     <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_CALC: begin
                    r_acc   <= w_acc_next;
                    r_mag_b <= r_mag_b >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                ST_DONE: begin
                    r_p    <= w_result;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == ST_CALC) || (r_state == ST_DONE);
    assign done = r_done;
    assign p    = r_p;

endmodule
